keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_sync_2ff.sv | 27 ++
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 tb/tb_keypad_scanner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding and a
// one-hot index decoder that also reports whether the vector was exactly one-hot.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } onehot_t;

  // Row vectors up to 8 bits are zero-extended by the caller.
  function automatic onehot_t onehot_decode(input logic [7:0] vec);
    onehot_t res;
    int      n;
    res = '0;
    n   = 0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        res.idx = 3'(i);
        n++;
      end
    end
    res.valid = (n == 1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_sync_2ff.sv
// Two-flop synchronizer for the asynchronous row sense lines; used only when
// the keypad scanner is built with KEYPAD_SYNC_EN.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning matrix keypad controller with press/release debouncing.
// Define KEYPAD_SYNC_EN to pass the row inputs through a 2-flop synchronizer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int N_ROWS       = 4,
  parameter  int N_COLS       = 4,
  parameter  int SCAN_DIV     = 1000,
  parameter  int DEBOUNCE_CYC = 50000,
  localparam int CODE_W       = $clog2(N_ROWS * N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_ROWS-1:0] rows,
  output logic [N_COLS-1:0] col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int COL_W   = $clog2(N_COLS);
  localparam int ROW_W   = $clog2(N_ROWS);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_DONE  = CNT_W'(DEBOUNCE_CYC);

  logic [N_ROWS-1:0] rows_s;

`ifdef KEYPAD_SYNC_EN
  sync_2ff #(.WIDTH(N_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rows),
    .q_o   (rows_s)
  );
`else
  assign rows_s = rows;
`endif

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [ROW_W-1:0]  row_idx_q, row_idx_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  db_q, db_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;

  onehot_t           hit;
  logic [N_ROWS-1:0] row_oh;
  logic [COL_W-1:0]  col_next;
  logic [CNT_W-1:0]  db_inc;
  logic [CODE_W-1:0] code;
  logic              row_low;

  assign hit      = onehot_decode(8'(rows_s));
  assign row_oh   = N_ROWS'(1) << row_idx_q;
  assign row_low  = ((rows_s & row_oh) == '0);
  assign col_next = (col_idx_q == COL_W'(N_COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
  assign db_inc   = (db_q == DB_DONE) ? db_q : db_q + CNT_W'(1);
  assign code     = CODE_W'(int'(row_idx_q) * N_COLS + int'(col_idx_q));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    div_d       = div_q;
    db_d        = db_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hit.valid) begin
            row_idx_d = ROW_W'(hit.idx);
            db_d      = '0;
            state_d   = PRESS_DB;
          end else begin
            col_idx_d = col_next;
          end
        end else begin
          div_d = div_q + CNT_W'(1);
        end
      end
      PRESS_DB: begin
        if (rows_s == row_oh) begin
          db_d = db_inc;
          if (db_inc == DB_DONE) begin
            key_code_d  = code;
            key_valid_d = 1'b1;
            state_d     = HELD;
          end
        end else begin
          col_idx_d = col_next;
          div_d     = '0;
          state_d   = SCAN;
        end
      end
      HELD: begin
        // Only the latched row matters once a key is accepted.
        if (row_low) begin
          db_d    = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (row_low) begin
          db_d = db_inc;
          if (db_inc == DB_DONE) begin
            col_idx_d = col_next;
            div_d     = '0;
            state_d   = SCAN;
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      div_q       <= '0;
      db_q        <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      div_q       <= div_d;
      db_q        <= db_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col       = N_COLS'(1) << col_idx_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows
// from the scanned column, and accepted key codes are checked against a queue.
module tb_keypad_scanner;

  localparam int NR  = 4;
  localparam int NC  = 4;
  localparam int DIV = 4;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] rows;
  logic [NC-1:0] col;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          key_held;

  logic [2:0]    rows2;
  logic [4:0]    col2;
  logic [3:0]    key_code2;
  logic          key_valid2;
  logic          key_held2;
  logic          press2;

  logic [NC-1:0][NR-1:0] keymap;
  logic                  force_en;
  logic [NR-1:0]         force_val;

  int checks    = 0;
  int errors    = 0;
  int valid_cnt = 0;
  int last_code = 0;
  int exp_q[$];

  keypad_scanner #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(DIV), .DEBOUNCE_CYC(DB)
  ) dut (
    .clk(clk), .reset(reset), .rows(rows), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  keypad_scanner #(
    .N_ROWS(3), .N_COLS(5), .SCAN_DIV(DIV), .DEBOUNCE_CYC(DB)
  ) dut2 (
    .clk(clk), .reset(reset), .rows(rows2), .col(col2),
    .key_code(key_code2), .key_valid(key_valid2), .key_held(key_held2)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its column drive to its row line.
  always_comb begin
    rows = '0;
    if (force_en) rows = force_val;
    else begin
      for (int c = 0; c < NC; c++)
        if (col[c]) rows = rows | keymap[c];
    end
  end

  assign rows2 = (press2 && col2[4]) ? 3'b100 : 3'b000;

  // Scoreboard: every key_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key_valid: got code %0d, no press expected", key_code);
      end else begin
        int exp_code;
        exp_code = exp_q.pop_front();
        if (key_code !== 4'(exp_code)) begin
          errors++;
          $display("FAIL key_code: got %0d, expected %0d", key_code, exp_code);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic expect_vec(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Returns on the first sample where col has just switched to target.
  task automatic wait_col_edge(input logic [NC-1:0] target);
    int n = 0;
    while (col === target && n < 100) begin tick(); n++; end
    while (col !== target && n < 100) begin tick(); n++; end
    expect_vec("wait_col_timeout", 8'(col), 8'(target));
  endtask

  task automatic test_reset();
    reset = 1'b1; keymap = '0; force_en = 1'b0; force_val = '0; press2 = 1'b0;
    tick(3);
    expect_vec("reset_col", 8'(col), 8'h01);
    expect_vec("reset_key_code", 8'(key_code), 8'h00);
    expect_bit("reset_key_valid", key_valid, 1'b0);
    expect_bit("reset_key_held", key_held, 1'b0);
    expect_vec("reset_col2", 8'(col2), 8'h01);
    expect_vec("reset_key_code2", 8'(key_code2), 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_press();
    int v0;
    wait_col_edge(4'b0010);
    v0 = valid_cnt;
    keymap[1][2] = 1'b1;
    exp_q.push_back(9);
    // 4 dwell cycles of the column, then 8 debounce cycles.
    tick(DIV + DB - 1);
    expect_bit("press_valid_early", key_valid, 1'b0);
    tick();
    expect_bit("press_valid_on_time", key_valid, 1'b1);
    expect_bit("press_held", key_held, 1'b1);
    tick();
    expect_bit("press_valid_one_cycle", key_valid, 1'b0);
    tick(20 - DIV - DB - 1);
    keymap[1][2] = 1'b0;
    expect_vec("press_valid_count", 8'(valid_cnt - v0), 8'd1);
    tick(DB - 1);
    expect_bit("release_held_during_db", key_held, 1'b1);
    tick(2);
    expect_bit("release_held_dropped", key_held, 1'b0);
    expect_vec("key_code_holds", 8'(key_code), 8'd9);
    last_code = 9;
  endtask

  task automatic test_short_press();
    int v0;
    wait_col_edge(4'b0010);
    v0 = valid_cnt;
    keymap[1][2] = 1'b1;
    tick(5);
    keymap[1][2] = 1'b0;
    tick(3);
    expect_vec("short_col_resumes", 8'(col), 8'b0100);
    expect_bit("short_no_held", key_held, 1'b0);
    expect_vec("short_code_unchanged", 8'(key_code), 8'(last_code));
    expect_vec("short_no_valid", 8'(valid_cnt - v0), 8'd0);
  endtask

  task automatic test_multi_hot();
    int v0;
    v0 = valid_cnt;
    force_en = 1'b1;
    force_val = 4'b1010;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int k = 0; k <= DIV * NC + DIV; k++) begin
      expect_vec("multihot_col_cycle", 8'(col), 8'(1 << ((k / DIV) % NC)));
      expect_bit("multihot_no_held", key_held, 1'b0);
      tick();
    end
    force_en = 1'b0;
    expect_vec("multihot_no_valid", 8'(valid_cnt - v0), 8'd0);
    last_code = 0;
  endtask

  task automatic test_other_rows();
    int v0;
    wait_col_edge(4'b1000);
    keymap[3][0] = 1'b1;
    exp_q.push_back(3);
    tick(DIV + DB + 2);
    v0 = valid_cnt;
    keymap[3][2] = 1'b1;
    tick(10);
    expect_bit("other_rows_held", key_held, 1'b1);
    keymap[3] = '0;
    tick(DB + 4);
    expect_bit("other_rows_released", key_held, 1'b0);
    expect_vec("other_rows_no_extra_valid", 8'(valid_cnt - v0), 8'd0);
    expect_vec("other_rows_code", 8'(key_code), 8'd3);
  endtask

  task automatic test_glitch();
    int v0;
    wait_col_edge(4'b0001);
    v0 = valid_cnt;
    keymap[0][3] = 1'b1;
    exp_q.push_back(12);
    tick(90);
    keymap[0][3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_bit("glitch_held_low", key_held, 1'b1);
    end
    keymap[0][3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_bit("glitch_held_recover", key_held, 1'b1);
    end
    tick(200 - 96);
    keymap[0][3] = 1'b0;
    tick(DB - 1);
    expect_bit("glitch_release_db", key_held, 1'b1);
    tick(2);
    expect_bit("glitch_release_done", key_held, 1'b0);
    expect_vec("glitch_one_valid", 8'(valid_cnt - v0), 8'd1);
  endtask

  task automatic test_reset_in_held();
    wait_col_edge(4'b0100);
    keymap[2][1] = 1'b1;
    exp_q.push_back(6);
    tick(DIV + DB + 3);
    expect_bit("held_before_reset", key_held, 1'b1);
    reset = 1'b1;
    tick();
    expect_bit("rst_held_key_held", key_held, 1'b0);
    expect_bit("rst_held_key_valid", key_valid, 1'b0);
    expect_vec("rst_held_key_code", 8'(key_code), 8'd0);
    expect_vec("rst_held_col", 8'(col), 8'h01);
    keymap = '0;
    reset = 1'b0;
    tick();
    expect_vec("rst_restart_col", 8'(col), 8'h01);
  endtask

  task automatic test_dut2();
    int  n = 0;
    press2 = 1'b1;
    while (key_valid2 !== 1'b1 && n < 300) begin tick(); n++; end
    expect_bit("dut2_valid_seen", key_valid2, 1'b1);
    expect_vec("dut2_key_code", 8'(key_code2), 8'd14);
    expect_bit("dut2_key_held", key_held2, 1'b1);
    press2 = 1'b0;
    tick(DB + 4);
    expect_bit("dut2_released", key_held2, 1'b0);
    expect_vec("dut2_code_holds", 8'(key_code2), 8'd14);
  endtask

  initial begin
    test_reset();
    test_press();
    test_short_press();
    test_multi_hot();
    test_other_rows();
    test_glitch();
    test_reset_in_held();
    test_dut2();
    tick(2);
    expect_vec("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
